// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the MIPS multicycle sequencer: FSM states,
// instruction classes, opcode/funct values and ALU operation codes.
package mips_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_WB,
    ST_HALT
  } state_e;

  typedef enum logic [3:0] {
    CLS_R,
    CLS_JR,
    CLS_LW,
    CLS_SW,
    CLS_BEQ,
    CLS_ADDI,
    CLS_J,
    CLS_JAL,
    CLS_HALT,
    CLS_ILL
  } iclass_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_JR  = 6'b001000;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/mips_alu_decoder.sv
// Combinational instruction classifier: maps opcode/funct to an instruction
// class, the ALU operation for EXEC/WB, and an illegal-encoding flag.
module mips_alu_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  output iclass_e    iclass_o,
  output logic [2:0] aluop_o,
  output logic       illegal_o
);

  always_comb begin
    iclass_o = CLS_ILL;
    aluop_o  = ALU_AND;
    case (opcode_i)
      OP_RTYPE: begin
        iclass_o = CLS_R;
        case (funct_i)
          FN_ADD:  aluop_o = ALU_ADD;
          FN_SUB:  aluop_o = ALU_SUB;
          FN_AND:  aluop_o = ALU_AND;
          FN_OR:   aluop_o = ALU_OR;
          FN_SLT:  aluop_o = ALU_SLT;
          FN_JR:   iclass_o = CLS_JR;
          default: iclass_o = CLS_ILL;
        endcase
      end
      OP_LW:   begin iclass_o = CLS_LW;   aluop_o = ALU_ADD; end
      OP_SW:   begin iclass_o = CLS_SW;   aluop_o = ALU_ADD; end
      OP_ADDI: begin iclass_o = CLS_ADDI; aluop_o = ALU_ADD; end
      OP_BEQ:  begin iclass_o = CLS_BEQ;  aluop_o = ALU_SUB; end
      OP_J:    iclass_o = CLS_J;
      OP_JAL:  iclass_o = CLS_JAL;
      OP_HALT: iclass_o = CLS_HALT;
      default: iclass_o = CLS_ILL;
    endcase
    illegal_o = (iclass_o == CLS_ILL);
  end

endmodule

// File: rtl/mips_multicycle_sequencer.sv
// Four-phase (FETCH/DECODE/EXEC/WB) sequencer driving the MIPS datapath
// controls from state plus the latched instruction; runs from start to halt.
module mips_multicycle_sequencer
  import mips_ctrl_pkg::*;
#(
  parameter logic [15:0] MAX_INSTR = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] instruction,
  input  logic        zeroflag,
  output logic        ldinpc,
  output logic        initpc,
  output logic        JumpSrc,
  output logic        PCsignal,
  output logic        PCSrc,
  output logic        RegDst,
  output logic        RegWSrc,
  output logic        WriteSrc,
  output logic        RegWrite,
  output logic        MemtoReg,
  output logic        ALUSrc,
  output logic [2:0]  ALUoperation,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        busy,
  output logic        done,
  output logic        illegal,
  output logic        timeout,
  output logic [15:0] instr_count
);

  state_e      state_q, state_d;
  logic [31:0] ir_q, ir_d;
  logic        taken_q, taken_d;
  logic [15:0] cnt_q, cnt_d;
  logic        illegal_q, illegal_d;
  logic        timeout_q, timeout_d;
  iclass_e     cls;
  logic [2:0]  dec_aluop;
  logic        dec_illegal;
  logic        in_exec_wb, in_wb;
  logic        unused_ir_bits;

  assign unused_ir_bits = ^ir_q[25:6];

  mips_alu_decoder u_dec (
    .opcode_i  (ir_q[31:26]),
    .funct_i   (ir_q[5:0]),
    .iclass_o  (cls),
    .aluop_o   (dec_aluop),
    .illegal_o (dec_illegal)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      ir_q      <= '0;
      taken_q   <= 1'b0;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      taken_q   <= taken_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    ir_d         = ir_q;
    taken_d      = taken_q;
    cnt_d        = cnt_q;
    illegal_d    = illegal_q;
    timeout_d    = timeout_q;
    ldinpc       = 1'b0;
    initpc       = 1'b0;
    JumpSrc      = 1'b0;
    PCsignal     = 1'b0;
    PCSrc        = 1'b0;
    RegDst       = 1'b0;
    RegWSrc      = 1'b0;
    WriteSrc     = 1'b0;
    RegWrite     = 1'b0;
    MemtoReg     = 1'b0;
    ALUSrc       = 1'b0;
    ALUoperation = ALU_AND;
    MemRead      = 1'b0;
    MemWrite     = 1'b0;
    in_exec_wb   = (state_q == ST_EXEC) || (state_q == ST_WB);
    in_wb        = (state_q == ST_WB);
    busy         = (state_q != ST_IDLE) && (state_q != ST_HALT);
    done         = (state_q == ST_HALT);

    // Flags and count clear on the way into INIT so INIT already shows them cleared.
    case (state_q)
      ST_IDLE, ST_HALT: begin
        if (start) begin
          state_d   = ST_INIT;
          cnt_d     = '0;
          illegal_d = 1'b0;
          timeout_d = 1'b0;
        end
      end
      ST_INIT: begin
        initpc  = 1'b1;
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        ir_d    = instruction;
        state_d = ST_DECODE;
      end
      ST_DECODE: begin
        if (cls == CLS_HALT) begin
          state_d = ST_HALT;
        end else if (dec_illegal) begin
          state_d   = ST_HALT;
          illegal_d = 1'b1;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        taken_d = (cls == CLS_BEQ) && zeroflag;
        state_d = ST_WB;
      end
      ST_WB: begin
        cnt_d = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
        if (({1'b0, cnt_q} + 17'd1) == {1'b0, MAX_INSTR}) begin
          state_d   = ST_HALT;
          timeout_d = 1'b1;
        end else begin
          state_d = ST_FETCH;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (in_exec_wb) begin
      ALUoperation = dec_aluop;
      case (cls)
        CLS_R:    RegDst = 1'b1;
        CLS_JR:   begin RegDst = 1'b1; PCsignal = 1'b1; end
        CLS_LW:   begin ALUSrc = 1'b1; MemtoReg = 1'b1; MemRead = 1'b1; end
        CLS_SW:   begin ALUSrc = 1'b1; MemWrite = (state_q == ST_EXEC); end
        CLS_ADDI: ALUSrc = 1'b1;
        CLS_J:    begin JumpSrc = 1'b1; PCsignal = 1'b1; end
        CLS_JAL:  begin RegWSrc = 1'b1; WriteSrc = 1'b1; JumpSrc = 1'b1; PCsignal = 1'b1; end
        default:  ;
      endcase
      RegWrite = in_wb && ((cls == CLS_R) || (cls == CLS_ADDI) ||
                           (cls == CLS_LW) || (cls == CLS_JAL));
      ldinpc   = in_wb;
      PCSrc    = in_wb && taken_q;
    end

    // A reset cycle must never commit architectural state.
    RegWrite = RegWrite && !rst;
    MemWrite = MemWrite && !rst;
    ldinpc   = ldinpc && !rst;
    initpc   = initpc && !rst;
  end

  assign illegal     = illegal_q;
  assign timeout     = timeout_q;
  assign instr_count = cnt_q;

endmodule

// File: doc/mips_multicycle_sequencer.md
# mips_multicycle_sequencer

Sequencing controller for the MIPS single-cycle datapath (`MIPSDatapath`). It runs the datapath as a fixed four-phase machine (FETCH, DECODE, EXEC, WB) per instruction and latches the fetched instruction. It produces every datapath control strobe, including PC load and init, and runs a program from a `start` pulse until a HALT opcode, an illegal opcode or an instruction-count watchdog. The block sits beside the datapath: it consumes `instruction` and `zeroflag` and drives all datapath control inputs.

## Interface
- `MAX_INSTR`, default 16'hFFFF: watchdog limit; HALT with `timeout` when the retired count reaches it.
- `clk`  in  1  single system clock; all state changes on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begin program; sampled only in IDLE or HALT.
- `instruction`  in  32  datapath instruction word.
- `zeroflag`  in  1  datapath ALU zero flag.
- `ldinpc`, `initpc`, `JumpSrc`, `PCsignal`, `PCSrc`  out  1 each  PC control.
- `RegDst`, `RegWSrc`, `WriteSrc`, `RegWrite`, `MemtoReg`  out  1 each  register-file write path control.
- `ALUSrc`  out  1  ALU B select.
- `ALUoperation`  out  3  ALU op: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT.
- `MemRead`, `MemWrite`  out  1 each  data memory strobes.
- `busy`  out  1  high in INIT, FETCH, DECODE, EXEC, WB.
- `done`  out  1  high in HALT.
- `illegal`, `timeout`  out  1 each  sticky halt cause; cleared on INIT.
- `instr_count`  out  16  retired instructions since last INIT.

## Operation
- States and transitions:
  - IDLE→INIT on `start`.
  - INIT→FETCH.
  - FETCH→DECODE.
  - DECODE→EXEC, or DECODE→HALT on a HALT or illegal opcode.
  - EXEC→WB.
  - WB→FETCH, or WB→HALT when `instr_count`+1 equals `MAX_INSTR`.
  - HALT→INIT on `start`.
- INIT asserts `initpc`, clears `instr_count`, `illegal` and `timeout`.
- FETCH: `ir` <= `instruction` at end of cycle; all strobes 0.
- DECODE: strobes 0; opcode `ir[31:26]` and funct `ir[5:0]` are classified.
- Supported opcodes:
  - R-type 000000 with funct add 100000, sub 100010, and 100100, or 100101, slt 101010, jr 001000.
  - lw 100011, sw 101011, beq 000100, addi 001000, j 000010, jal 000011.
  - HALT 111111 sets no flag.
  - Any other opcode or funct sets `illegal`.
- EXEC/WB static selects, held through both phases:
  - R-type: `RegDst`=1, ALUoperation from funct.
  - addi and lw: `ALUSrc`=1, ADD.
  - lw: `MemtoReg`=1.
  - sw: `ALUSrc`=1, ADD.
  - beq: SUB.
  - jal: `RegWSrc`=1, `WriteSrc`=1.
  - j and jal: `JumpSrc`=1, `PCsignal`=1.
  - jr: `JumpSrc`=0, `PCsignal`=1.
- Strobes:
  - `MemRead` in EXEC and WB for lw.
  - `MemWrite` in EXEC only, for sw.
  - `RegWrite` in WB only, for R-type (except jr), addi, lw and jal.
  - `ldinpc` in WB only, for every retired instruction.
- Branch: `taken` <= `zeroflag` at end of EXEC for beq. `PCSrc`=`taken` in WB.
- Counter: +1 at end of each WB, saturating at 16'hFFFF.
- Outputs not listed for a state are 0.

## Timing
- All outputs are Moore: decoded from state plus registered `ir` and `taken`. No combinational path from `instruction` or `zeroflag` to outputs.
- Every instruction takes 4 cycles. The PC updates on the rising edge ending WB.
- Latency: `start` at edge N gives `initpc`=1 in cycle N+1 and the first FETCH in cycle N+2.
- A HALT instruction takes FETCH plus DECODE, then enters HALT. It is not counted.
- `start` while `busy` is ignored. `start` held high in HALT re-runs the program.
- Reset values: state IDLE, every output 0, `instr_count` 0, `ir` 0, `taken` 0.
- `rst` mid-instruction: the next edge gives IDLE. No write strobe is emitted in the reset cycle or after it.
- Watchdog and illegal opcode reached in the same instruction: illegal wins, because the instruction is never executed.

## Structure
- Package `mips_ctrl_pkg` holds:
  - the state enum;
  - opcode and funct localparams;
  - ALU op localparams (AND, OR, ADD, SUB, SLT).
- Sub-module `mips_alu_decoder`: combinational mapping from funct/opcode class to `ALUoperation` plus an illegal flag.
- Top contains the FSM, `ir`/`taken` registers and the counter.

## Test plan
- Reset, then pulse `start`, then feed addi (0x20080005): `initpc` for 1 cycle; over the 4 phases `RegWrite`=1 and `ldinpc`=1 only in WB, `ALUSrc`=1, `ALUoperation`=010, `instr_count`=1.
- sw (0xAC090004) followed by lw (0x8C0A0004): `MemWrite` only in sw EXEC; `MemRead` in lw EXEC+WB with `MemtoReg`=1.
- beq (0x11090002) with `zeroflag`=1 in EXEC: `PCSrc`=1 in WB. With `zeroflag`=0: `PCSrc`=0, while `zeroflag` toggling in WB has no effect.
- jal (0x0C000010): `RegWSrc`=`WriteSrc`=`JumpSrc`=`PCsignal`=1 in WB. jr $31 (0x03E00008): `JumpSrc`=0, `PCsignal`=1, `RegWrite`=0.
- Opcode 0x3F gives `done`=1 after DECODE with `illegal`=0. Opcode 0x3E gives `done`=1 with `illegal`=1. A second `start` clears both flags and `instr_count`.
- `MAX_INSTR`=3 with a stream of adds: `timeout`=1 and `done`=1 after the third WB. `rst` asserted in EXEC gives all outputs 0 on the next cycle.
